uart_rx_oversampled: RTL and testbench
======================================

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
Parameters, one per line: name, default, meaning.
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning the number of data bits per frame (legal range 5..8).
REQ-002 The block SHALL have parameter OVERSAMP_RATE, default 16, meaning tick enables per bit period; the value is fixed at 16.

Ports, one per line: name, direction, width, meaning.
REQ-003 clk_i  in  1  system clock; all logic is on its rising edge.
REQ-004 reset_n_i  in  1  reset; asynchronous, active-low.
REQ-005 clk16_en_i  in  1  single-cycle oversample enable pulse at 16x the baud rate, from the team's baud divider.
REQ-006 rx_i  in  1  asynchronous serial line; idle high.
REQ-007 ready_i  in  1  consumer accepts data_o in any cycle where valid_o=1 and ready_i=1.
REQ-008 data_o  out  DATA_BITS  received byte; bit 0 is the first data bit on the line.
REQ-009 valid_o  out  1  data_o holds an unconsumed byte.
REQ-010 frame_err_o  out  1  one-cycle pulse when the stop bit is sampled low.
REQ-011 overrun_o  out  1  one-cycle pulse when a good frame completes while valid_o=1.
REQ-012 busy_o  out  1  high whenever the state machine is not IDLE.

Function
REQ-013 rx_i SHALL pass through a 2-flop synchronizer, initialised to 1, before any use; the result is rxs.
REQ-014 The state machine SHALL have the states IDLE, START, DATA and STOP, a 4-bit tick counter cnt, and a bit counter bcnt.
REQ-015 cnt and bcnt SHALL change only in clk_i cycles where clk16_en_i=1, except that they are cleared on a state entry.
REQ-016 IDLE: when rxs=0 in a tick cycle -> go to START with cnt=0.
REQ-017 START: each tick increments cnt; on the tick where cnt=7 (mid start bit), rxs=0 -> go to DATA with cnt=0 and bcnt=0, and rxs=1 -> go to IDLE (glitch rejected, no output).
REQ-018 DATA: each tick increments cnt; on the tick where cnt=15, rxs SHALL be shifted in LSB-first, cnt wraps to 0, and bcnt increments.
REQ-019 DATA: after bit DATA_BITS-1 is sampled -> go to STOP.
REQ-020 STOP: on the tick where cnt=15, rxs=1 is a good frame and rxs=0 is a framing error; in both cases go to IDLE in the same cycle, so the next start edge can be detected on the next tick.
REQ-021 On a good frame with valid_o=0, data_o SHALL load the shift register and valid_o SHALL be 1 from the next cycle.
REQ-022 On a good frame with valid_o=1, the new byte SHALL be discarded, data_o SHALL be unchanged, and overrun_o SHALL pulse for 1 cycle.
REQ-023 If valid_o&ready_i occurs in the same cycle as a good-frame completion, the new byte SHALL be loaded, valid_o SHALL stay 1, and there is no overrun.
REQ-024 On a framing error, frame_err_o SHALL pulse for 1 cycle, data_o and valid_o SHALL be unchanged, and there is no overrun.
REQ-025 valid_o SHALL clear the cycle after valid_o&ready_i, unless REQ-023 applies.
REQ-026 data_o SHALL remain stable while valid_o=1.
REQ-027 clk16_en_i=0 SHALL freeze the state, cnt and bcnt; the outputs keep their values apart from the single-cycle pulse rules.
REQ-028 Latency from the stop-bit mid-sample tick to valid_o=1 SHALL be exactly 1 clk_i cycle.

Reset
REQ-029 While reset_n_i=0, the state SHALL be IDLE; cnt, bcnt and the shift register SHALL be 0; the synchronizer flops SHALL be 1.
REQ-030 While reset_n_i=0, data_o SHALL be 0 and valid_o, frame_err_o, overrun_o and busy_o SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial byte with no pulse on any output; reception resumes only on a fresh falling edge after reset is released.

Verification
REQ-032 Frame 0xA5 at 16 ticks/bit with ready_i=0 -> data_o=0xA5; valid_o=1 and held; frame_err_o=0.
REQ-033 rx_i low for 4 ticks then high -> back to IDLE; no valid_o and no frame_err_o; busy_o falls after the cnt=7 tick.
REQ-034 Frame 0x3C with the stop bit driven 0 -> frame_err_o is a single-cycle pulse and valid_o stays 0.
REQ-035 0x11 sent, not consumed, then 0x22 sent -> overrun_o pulses once and data_o remains 0x11.
REQ-036 Back-to-back 0x00 then 0xFF with no idle gap and ready_i=1 -> two valid_o handshakes with data_o=0x00, then 0xFF.
REQ-037 reset_n_i pulsed low during bit 3 of 0x5A, then a full 0x81 frame sent -> only 0x81 is received.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver with valid/ready output.
module uart_rx_oversampled #(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMP_RATE = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 clk16_en_i,
  input  logic                 rx_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam logic [3:0] CNT_LAST = 4'(OVERSAMP_RATE - 1);
  localparam logic [3:0] CNT_MID  = 4'(OVERSAMP_RATE / 2 - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   sync1_q, rxs;
  logic                   good_frame, bad_frame;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rxs     <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    if (clk16_en_i) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CNT_MID) begin
            // Start bit must still be low at its centre, else it was a glitch
            state_d = rxs ? IDLE : DATA;
            cnt_d   = '0;
            bcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        DATA: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == LAST_BIT) begin
              state_d = STOP;
              cnt_d   = '0;
            end
          end
        end
        STOP: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            state_d    = IDLE;
            cnt_d      = '0;
            good_frame = rxs;
            bad_frame  = !rxs;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= bad_frame;
      overrun_o   <= 1'b0;
      if (good_frame) begin
        // A same-cycle handshake frees the holding register for the new byte
        if (!valid_o || ready_i) begin
          data_o  <= shreg_q;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed self-checking bench for uart_rx_oversampled.
module tb_uart_rx_oversampled;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       clk16_en_i;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int hs_cnt = 0;
  logic [7:0] hs_data [0:15];
  int div = 0;

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMP_RATE(16)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .clk16_en_i  (clk16_en_i),
    .rx_i        (rx_i),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // One oversample tick every 4 clocks
  initial begin
    clk16_en_i = 1'b0;
    forever begin
      @(negedge clk_i);
      div = (div + 1) % 4;
      clk16_en_i = (div == 0);
    end
  end

  always @(negedge clk_i) begin
    if (frame_err_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
    if (valid_o && ready_i) begin
      if (hs_cnt < 16) hs_data[hs_cnt] = data_o;
      hs_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input int n);
    repeat (n) begin
      do @(posedge clk_i); while (!clk16_en_i);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    wait_tick(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic consume();
    @(negedge clk_i);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  initial begin
    int base;
    int fe_base;
    int ov_base;
    logic prev_valid;
    logic done;

    reset_n_i = 1'b0;
    rx_i      = 1'b1;
    ready_i   = 1'b0;
    repeat (5) @(negedge clk_i);
    check("reset_data", data_o, 8'h00);
    check("reset_valid", valid_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_ferr", frame_err_o, 1'b0);
    check("reset_ovr", overrun_o, 1'b0);
    reset_n_i = 1'b1;
    wait_tick(4);

    // 0xA5 with exact one-cycle latency from the stop sample
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(logic'(8'hA5 >> i));
    rx_i = 1'b1;
    done = 1'b0;
    prev_valid = valid_o;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin
        done = 1'b1;
        break;
      end
      prev_valid = valid_o;
    end
    check("a5_stop_seen", done, 1'b1);
    check("a5_valid_before", prev_valid, 1'b0);
    check("a5_valid_latency", valid_o, 1'b1);
    check("a5_data", data_o, 8'hA5);
    wait_tick(8);
    repeat (20) @(negedge clk_i);
    check("a5_valid_held", valid_o, 1'b1);
    check("a5_data_held", data_o, 8'hA5);
    check("a5_no_ferr", fe_cnt, 0);
    consume();
    @(negedge clk_i);
    check("a5_valid_clr", valid_o, 1'b0);
    wait_tick(2);

    // Start glitch of 4 ticks
    rx_i = 1'b0;
    wait_tick(4);
    check("glitch_busy", busy_o, 1'b1);
    rx_i = 1'b1;
    wait_tick(10);
    check("glitch_idle", busy_o, 1'b0);
    check("glitch_valid", valid_o, 1'b0);
    check("glitch_ferr", fe_cnt, 0);
    wait_tick(4);

    // Framing error
    send_frame(8'h3C, 1'b0);
    rx_i = 1'b1;
    wait_tick(16);
    check("ferr_count", fe_cnt, 1);
    check("ferr_valid", valid_o, 1'b0);
    check("ferr_busy", busy_o, 1'b0);

    // Overrun
    ov_base = ov_cnt;
    send_frame(8'h11, 1'b1);
    check("ovr_first_valid", valid_o, 1'b1);
    check("ovr_first_data", data_o, 8'h11);
    send_frame(8'h22, 1'b1);
    check("ovr_count", ov_cnt - ov_base, 1);
    check("ovr_data_kept", data_o, 8'h11);
    check("ovr_valid_kept", valid_o, 1'b1);
    consume();
    wait_tick(2);

    // Back-to-back with consumer always ready
    base = hs_cnt;
    ready_i = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_tick(2);
    ready_i = 1'b0;
    check("b2b_count", hs_cnt - base, 2);
    if (hs_cnt - base == 2 && hs_cnt <= 16) begin
      check("b2b_first", hs_data[base], 8'h00);
      check("b2b_second", hs_data[base+1], 8'hFF);
    end
    check("b2b_valid", valid_o, 1'b0);

    // Reset during bit 3 of 0x5A, then 0x81
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    base = hs_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(logic'(8'h5A >> i));
    rx_i = 1'b1;
    wait_tick(5);
    check("rst_busy_before", busy_o, 1'b1);
    @(negedge clk_i);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_busy", busy_o, 1'b0);
    check("rst_mid_valid", valid_o, 1'b0);
    check("rst_mid_data", data_o, 8'h00);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    wait_tick(20);
    check("rst_idle", busy_o, 1'b0);
    check("rst_no_valid", valid_o, 1'b0);
    send_frame(8'h81, 1'b1);
    check("rst_81_valid", valid_o, 1'b1);
    check("rst_81_data", data_o, 8'h81);
    check("rst_no_ferr", fe_cnt - fe_base, 0);
    check("rst_no_ovr", ov_cnt - ov_base, 0);
    check("rst_no_hs", hs_cnt - base, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
